pulse_meter: RTL and testbench

- Measures how long a level input stays high, in clock periods. It is the measuring counterpart of the countdown timer.
- Typical use: qualifying camera sync/strobe widths (VSYNC, HREF, PMOD strobes) before data is forwarded on the PMOD data-out path.
- Each completed pulse width is reported on a valid/ready output handshake, with saturation and overflow flagging.

---
 rtl/pulse_meter.sv | 101 ++++++++++
 tb/tb_pulse_meter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_meter.sv
// pulse_meter: measures how many consecutive clock edges a synchronous level
// input is sampled high, and reports each completed width on a valid/ready
// handshake. Widths saturate at max_periods_g; longer pulses raise overflow_o.
// Rising edges that arrive while a result is waiting are flagged on drop_o.
module pulse_meter #(
  parameter int max_periods_g = 1024,
  localparam int cnt_w = $clog2(max_periods_g + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             level_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [cnt_w-1:0] periods_o,
  output logic             overflow_o,
  output logic             busy_o,
  output logic             drop_o
);

  // FSM encoding
  localparam logic [1:0] ST_ARM     = 2'd0;
  localparam logic [1:0] ST_IDLE    = 2'd1;
  localparam logic [1:0] ST_MEASURE = 2'd2;
  localparam logic [1:0] ST_REPORT  = 2'd3;

  localparam logic [cnt_w-1:0] max_cnt = cnt_w'(max_periods_g);
  localparam logic [cnt_w-1:0] one_cnt = cnt_w'(1);

  logic [1:0]       state;
  logic [cnt_w-1:0] counter;
  logic             ovf_flag;
  logic             prev_level;

  // Main measurement FSM: arm on a low, count high samples, hold the result until accepted
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_ARM;
      counter    <= '0;
      ovf_flag   <= 1'b0;
      valid_o    <= 1'b0;
      periods_o  <= '0;
      overflow_o <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      case (state)
        ST_ARM: begin
          // Never measure a pulse that was already high when we armed
          if (!level_i) begin
            state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (level_i) begin
            state   <= ST_MEASURE;
            counter <= one_cnt;
            busy_o  <= 1'b1;
          end
        end
        ST_MEASURE: begin
          if (level_i) begin
            // Saturate instead of wrapping; remember that we clipped
            if (counter < max_cnt) begin
              counter <= counter + one_cnt;
            end else begin
              ovf_flag <= 1'b1;
            end
          end else begin
            periods_o  <= counter;
            overflow_o <= ovf_flag;
            valid_o    <= 1'b1;
            busy_o     <= 1'b0;
            state      <= ST_REPORT;
          end
        end
        ST_REPORT: begin
          // valid_o is a register, so ready_i only affects it through this edge
          if (ready_i) begin
            valid_o  <= 1'b0;
            ovf_flag <= 1'b0;
            state    <= ST_ARM;
          end
        end
        default: begin
          state <= ST_ARM;
        end
      endcase
    end
  end

  // Edge tracking and one-cycle strobe for rises that land while a result is pending
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_level <= 1'b1;
      drop_o     <= 1'b0;
    end else begin
      prev_level <= level_i;
      drop_o     <= (state == ST_REPORT) && level_i && !prev_level;
    end
  end

endmodule

// File: tb/tb_pulse_meter.sv
// Self-checking bench for pulse_meter (max_periods_g = 16). Stimulus is driven
// and outputs are sampled on the falling clock edge. Expected results come from
// the pulse lengths the bench itself drove: width = min(len, 16), overflow = len > 16.
module tb_pulse_meter;

  localparam int max_p = 16;
  localparam int cw    = $clog2(max_p + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          level;
  logic          ready;
  logic          valid;
  logic [cw-1:0] periods;
  logic          overflow;
  logic          busy;
  logic          drop;

  int n_checks = 0;
  int n_fail   = 0;

  pulse_meter #(.max_periods_g(max_p)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .level_i   (level),
    .ready_i   (ready),
    .valid_o   (valid),
    .periods_o (periods),
    .overflow_o(overflow),
    .busy_o    (busy),
    .drop_o    (drop)
  );

  always #5 clk = ~clk;

  // Watchdog: the run must always terminate
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Drive level high for exactly len sampling edges, then drop it
  task automatic drive_pulse(input int len);
    level = 1'b1;
    repeat (len) tick();
    level = 1'b0;
  endtask

  // Advance until valid is seen, bounded; ok=0 if the bound expired
  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic int exp_width(input int len);
    return (len > max_p) ? max_p : len;
  endfunction

  task automatic test_reset();
    bit ok;
    rst = 1'b1; level = 1'b1; ready = 1'b1;
    #1;
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (periods !== '0) begin n_fail++; $display("FAIL reset_periods: got %0d expected 0", periods); end
    n_checks++; if (overflow !== 1'b0 || drop !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got ovf=%b drop=%b expected 0 0", overflow, drop); end
    tick(); tick();
    rst = 1'b0;
    // Pulse in progress at reset must be ignored
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (busy !== 1'b0 || valid !== 1'b0) begin n_fail++; $display("FAIL reset_partial: got busy=%b valid=%b expected 0 0", busy, valid); end
    end
    level = 1'b0;
    repeat (3) tick();
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_partial_result: got valid=%b expected 0", valid); end
    drive_pulse(4);
    wait_valid(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL reset_p4_timeout: got no valid expected valid"); end
    n_checks++; if (periods !== cw'(4)) begin n_fail++; $display("FAIL reset_p4_periods: got %0d expected 4", periods); end
    $display("reset test: pulse 4 -> periods=%0d ovf=%b", periods, overflow);
    tick();
    repeat (3) tick();
  endtask

  task automatic test_basic_7();
    ready = 1'b1;
    level = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL p7_busy cycle %0d: got %b expected 1", i, busy); end
      n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL p7_early_valid cycle %0d: got %b expected 0", i, valid); end
    end
    level = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL p7_busy_fall: got %b expected 0", busy); end
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL p7_valid: got %b expected 1", valid); end
    n_checks++; if (periods !== cw'(7)) begin n_fail++; $display("FAIL p7_periods: got %0d expected 7", periods); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL p7_overflow: got %b expected 0", overflow); end
    $display("basic test: pulse 7 -> periods=%0d ovf=%b", periods, overflow);
    tick();
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL p7_valid_one_cycle: got %b expected 0", valid); end
    repeat (3) tick();
  endtask

  task automatic test_single_cycle();
    ready = 1'b1;
    drive_pulse(1);
    tick();
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL p1_valid: got %b expected 1", valid); end
    n_checks++; if (periods !== cw'(1)) begin n_fail++; $display("FAIL p1_periods: got %0d expected 1", periods); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL p1_overflow: got %b expected 0", overflow); end
    $display("single test: pulse 1 -> periods=%0d ovf=%b", periods, overflow);
    repeat (4) tick();
  endtask

  task automatic test_saturation();
    int lens [2] = '{16, 20};
    bit ok;
    ready = 1'b1;
    foreach (lens[k]) begin
      drive_pulse(lens[k]);
      wait_valid(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL sat_timeout len %0d: got no valid expected valid", lens[k]); end
      n_checks++; if (periods !== cw'(exp_width(lens[k]))) begin n_fail++; $display("FAIL sat_periods len %0d: got %0d expected %0d", lens[k], periods, exp_width(lens[k])); end
      n_checks++; if (overflow !== (lens[k] > max_p)) begin n_fail++; $display("FAIL sat_overflow len %0d: got %b expected %b", lens[k], overflow, lens[k] > max_p); end
      $display("saturation test: pulse %0d -> periods=%0d ovf=%b", lens[k], periods, overflow);
      repeat (4) tick();
    end
  endtask

  task automatic test_drop();
    bit ok;
    int n_valid;
    ready = 1'b0;
    drive_pulse(3);
    wait_valid(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL drop_timeout: got no valid expected valid"); end
    // Second pulse while the result is pending
    level = 1'b1;
    tick();
    n_checks++; if (drop !== 1'b1) begin n_fail++; $display("FAIL drop_strobe: got %b expected 1", drop); end
    tick();
    n_checks++; if (drop !== 1'b0) begin n_fail++; $display("FAIL drop_one_cycle: got %b expected 0", drop); end
    tick();
    level = 1'b0;
    tick();
    n_checks++; if (valid !== 1'b1 || periods !== cw'(3) || overflow !== 1'b0) begin n_fail++; $display("FAIL drop_hold: got valid=%b periods=%0d ovf=%b expected 1 3 0", valid, periods, overflow); end
    $display("drop test: held result periods=%0d ovf=%b", periods, overflow);
    ready = 1'b1;
    n_valid = 0;
    for (int i = 0; i < 6; i++) begin
      if (valid === 1'b1) n_valid++;
      tick();
    end
    n_checks++; if (n_valid !== 1) begin n_fail++; $display("FAIL drop_single_transfer: got %0d expected 1", n_valid); end
    drive_pulse(9);
    wait_valid(ok);
    n_checks++; if (!ok || periods !== cw'(9)) begin n_fail++; $display("FAIL drop_p9: got ok=%b periods=%0d expected 1 9", ok, periods); end
    $display("drop test: pulse 9 -> periods=%0d ovf=%b", periods, overflow);
    repeat (4) tick();
  endtask

  task automatic test_back_to_back();
    bit ok;
    ready = 1'b0;
    drive_pulse(2);
    wait_valid(ok);
    n_checks++; if (!ok || periods !== cw'(2)) begin n_fail++; $display("FAIL b2b_first: got ok=%b periods=%0d expected 1 2", ok, periods); end
    tick();
    // Handshake and a rise on the same edge: rise is dropped
    ready = 1'b1;
    level = 1'b1;
    tick();
    n_checks++; if (drop !== 1'b1 || valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drop: got drop=%b valid=%b expected 1 0", drop, valid); end
    repeat (3) tick();
    level = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_not_measured: got valid=%b busy=%b expected 0 0", valid, busy); end
    end
    drive_pulse(2);
    wait_valid(ok);
    n_checks++; if (!ok || periods !== cw'(2)) begin n_fail++; $display("FAIL b2b_second: got ok=%b periods=%0d expected 1 2", ok, periods); end
    $display("back-to-back test: pulse 2 -> periods=%0d", periods);
    repeat (4) tick();
  endtask

  task automatic test_async_reset();
    bit ok;
    ready = 1'b1;
    level = 1'b1;
    repeat (3) tick();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL areset_busy_before: got %b expected 1", busy); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0 || valid !== 1'b0) begin n_fail++; $display("FAIL areset_immediate: got busy=%b valid=%b expected 0 0", busy, valid); end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL areset_no_result: got valid=%b busy=%b expected 0 0", valid, busy); end
    end
    level = 1'b0;
    repeat (2) tick();
    drive_pulse(5);
    wait_valid(ok);
    n_checks++; if (!ok || periods !== cw'(5) || overflow !== 1'b0) begin n_fail++; $display("FAIL areset_p5: got ok=%b periods=%0d ovf=%b expected 1 5 0", ok, periods, overflow); end
    $display("async reset test: pulse 5 -> periods=%0d ovf=%b", periods, overflow);
    repeat (4) tick();
  endtask

  task automatic test_random();
    bit ok;
    int len;
    int dly;
    for (int n = 0; n < 25; n++) begin
      len   = $urandom_range(1, 24);
      ready = 1'($urandom_range(0, 1));
      drive_pulse(len);
      wait_valid(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL rnd_timeout #%0d len %0d: got no valid expected valid", n, len); end
      n_checks++; if (periods !== cw'(exp_width(len)) || overflow !== (len > max_p)) begin
        n_fail++;
        $display("FAIL rnd_result #%0d len %0d: got periods=%0d ovf=%b expected %0d %b", n, len, periods, overflow, exp_width(len), len > max_p);
      end
      $display("random #%0d: pulse %0d -> periods=%0d ovf=%b", n, len, periods, overflow);
      if (ready == 1'b0) begin
        dly = $urandom_range(1, 5);
        repeat (dly) tick();
        n_checks++; if (valid !== 1'b1 || periods !== cw'(exp_width(len))) begin n_fail++; $display("FAIL rnd_hold #%0d: got valid=%b periods=%0d expected 1 %0d", n, valid, periods, exp_width(len)); end
        ready = 1'b1;
      end
      tick();
      n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rnd_accept #%0d: got valid=%b expected 0", n, valid); end
      repeat ($urandom_range(2, 5)) tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic_7();
    test_single_cycle();
    test_saturation();
    test_drop();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
